// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command front-end for the 4-bit ALU
// Registers one command onto the ALU inputs, captures the result and holds it for a downstream handshake.
module alu_cmd_sequencer #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4,
  parameter int RES_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_sel,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [RES_W-1:0]  alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [OP_W-1:0]   res_sel,
  output logic [DATA_W-1:0] acc,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_sel_q, alu_sel_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [OP_W-1:0]   res_sel_q, res_sel_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_src;

  // A clear arriving with the command is forwarded so operand a sees zero.
  assign acc_src = acc_clr ? '0 : acc_q;

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    res_data_d = res_data_q;
    res_sel_d  = res_sel_q;
    acc_d      = acc_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_sel_d = cmd_sel;
          alu_b_d   = cmd_b;
          alu_a_d   = cmd_use_acc ? acc_src : cmd_a;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_data_d = alu_y;
        res_sel_d  = alu_sel_q;
        acc_d      = alu_y[DATA_W-1:0];
        state_d    = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over the EXEC capture in every state.
    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      res_data_q <= '0;
      res_sel_q  <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      res_data_q <= res_data_d;
      res_sel_q  <= res_sel_d;
      acc_q      <= acc_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer
// A small ALU model closes the loop on alu_y; expected results are queued at issue and checked by a monitor.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_sel;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       acc_clr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic [4:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_data;
  logic [3:0] res_sel;
  logic [3:0] acc;
  logic       busy;

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .acc_clr    (acc_clr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_sel    (res_sel),
    .acc        (acc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU covering only the opcodes the vectors use.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    case (sel)
      4'b0000: alu_model = {1'b0, a} + 5'd1;
      4'b0101: alu_model = {1'b0, a} - {1'b0, b};
      4'b0110: alu_model = {1'b0, a} + {1'b0, b};
      4'b1000: alu_model = ~{1'b0, a};
      default: alu_model = {1'b0, a ^ b};
    endcase
  endfunction

  always_comb alu_y = alu_model(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [3:0] sel;
    logic [4:0] data;
    logic [3:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every result handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", {27'd0, res_data}, {27'd0, e.data});
        chk("res_sel", {28'd0, res_sel}, {28'd0, e.sel});
        chk("acc_after_capture", {28'd0, acc}, {28'd0, e.acc});
      end
    end
  end

  task automatic push_exp(input logic [3:0] sel, input logic [4:0] data, input logic [3:0] a);
    exp_t e;
    e.sel = sel; e.data = data; e.acc = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk(name, 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, input logic clr, input logic clr_exec,
                       input logic [3:0] exp_alu_a);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_use_acc = ua; acc_clr = clr;
    wait_ready("accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_use_acc = 1'b0; acc_clr = clr_exec;
    @(negedge clk);
    chk("alu_a", {28'd0, alu_a}, {28'd0, exp_alu_a});
    chk("alu_b", {28'd0, alu_b}, {28'd0, b});
    chk("alu_sel", {28'd0, alu_sel}, {28'd0, sel});
    chk("busy_exec", {31'd0, busy}, 32'd1);
    chk("cmd_ready_exec", {31'd0, cmd_ready}, 32'd0);
    if (clr_exec) begin
      @(posedge clk); #1;
      acc_clr = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b1;
    #22;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acc", {28'd0, acc}, 32'd0);
    chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
    chk("rst_res_data", {27'd0, res_data}, 32'd0);
    rst_n = 1'b1;

    // Basic add with explicit latency checks
    push_exp(4'b0110, 5'b00111, 4'b0111);
    issue(4'b0110, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4'd3);
    chk("res_valid_exec", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("res_valid_done", {31'd0, res_valid}, 32'd1);
    drain();

    // Logical op: 5-bit result passes through unchanged
    push_exp(4'b1000, 5'b11010, 4'b1010);
    issue(4'b1000, 4'b0101, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0101);
    drain();

    // Chain through the accumulator
    push_exp(4'b0000, 5'b00110, 4'd6);
    issue(4'b0000, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5);
    drain();
    push_exp(4'b0000, 5'b00111, 4'd7);
    issue(4'b0000, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6);
    drain();

    // Backpressure with a pending command held on the input
    res_ready = 1'b0;
    push_exp(4'b0110, 5'b00010, 4'd2);
    issue(4'b0110, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_sel = 4'(i + 1); cmd_a = 4'(i + 9); cmd_b = 4'(i);
      @(negedge clk);
      chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_res_data", {27'd0, res_data}, 32'd2);
      chk("bp_res_sel", {28'd0, res_sel}, 32'd6);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_alu_a", {28'd0, alu_a}, 32'd1);
    end
    @(posedge clk); #1;
    cmd_sel = 4'b0110; cmd_a = 4'd4; cmd_b = 4'd4;
    push_exp(4'b0110, 5'b01000, 4'd8);
    res_ready = 1'b1;
    wait_ready("bp_accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_pending_alu_a", {28'd0, alu_a}, 32'd4);
    chk("bp_pending_alu_sel", {28'd0, alu_sel}, 32'd6);
    drain();

    // Accumulator clear: forwarded at acceptance, then overriding EXEC capture
    push_exp(4'b0110, 5'b01001, 4'd9);
    issue(4'b0110, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, 4'd4);
    drain();
    push_exp(4'b0101, 5'b00000, 4'd0);
    issue(4'b0101, 4'd7, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    drain();
    push_exp(4'b0110, 5'b00100, 4'd0);
    issue(4'b0110, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1, 4'd2);
    drain();

    // Reset during EXEC aborts the command
    push_exp(4'b0000, 5'b00011, 4'd3);
    issue(4'b0000, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2);
    drain();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_sel = 4'b0110; cmd_a = 4'd1; cmd_b = 4'd2;
    wait_ready("rst_accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("async_rst_acc", {28'd0, acc}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
